// File: rtl/mux_pkg.sv
// Shared constants and vector types for the 11:1 single-bit selector.
package mux_pkg;
    localparam int NUM_IN = 11;
    localparam int SEL_W  = NUM_IN - 1;
    localparam int IDX_W  = 4;

    typedef logic [NUM_IN-1:0] data_vec_t;
    typedef logic [SEL_W-1:0]  sel_vec_t;
    typedef logic [IDX_W-1:0]  idx_t;
endpackage

// File: rtl/mux2_cell.sv
// Generic 2:1 mux cell; width is a parameter so the index path can reuse it.
module mux2_cell #(
    parameter int W = 1
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_11to1.sv
// 11:1 single-bit selector built from a cascade of ten 2:1 cells, with a
// registered data output and a registered index of the selected source.
module mux_11to1
    import mux_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  data_vec_t a,
    input  sel_vec_t  f,
    output logic      bigout,
    output idx_t      sel_idx
);
    logic [SEL_W-1:0] data_stage;
    idx_t             idx_stage [SEL_W];

    // Index path mirrors the data cascade on constants, so a higher set f
    // bit overrides every lower one exactly like the data path does.
    for (genvar gi = 0; gi < SEL_W; gi++) begin : g_cell
        if (gi == 0) begin : g_first
            mux2_cell #(.W(1)) u_data (
                .in0 (a[0]),
                .in1 (a[1]),
                .sel (f[0]),
                .out (data_stage[0])
            );
            mux2_cell #(.W(IDX_W)) u_idx (
                .in0 (IDX_W'(0)),
                .in1 (IDX_W'(1)),
                .sel (f[0]),
                .out (idx_stage[0])
            );
        end else begin : g_rest
            mux2_cell #(.W(1)) u_data (
                .in0 (data_stage[gi-1]),
                .in1 (a[gi+1]),
                .sel (f[gi]),
                .out (data_stage[gi])
            );
            mux2_cell #(.W(IDX_W)) u_idx (
                .in0 (idx_stage[gi-1]),
                .in1 (IDX_W'(gi + 1)),
                .sel (f[gi]),
                .out (idx_stage[gi])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bigout  <= 1'b0;
            sel_idx <= '0;
        end else begin
            bigout  <= data_stage[SEL_W-1];
            sel_idx <= idx_stage[SEL_W-1];
        end
    end
endmodule

// File: tb/tb_mux_11to1.sv
// Directed and random checks of the registered 11:1 selector.
module tb_mux_11to1;
    import mux_pkg::*;

    logic      clk;
    logic      rst_n;
    data_vec_t a;
    sel_vec_t  f;
    logic      bigout;
    idx_t      sel_idx;

    int tests_run;
    int tests_failed;

    mux_11to1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .f       (f),
        .bigout  (bigout),
        .sel_idx (sel_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (actual timeout, required finish)");
        $fatal(1, "timeout");
    end

    function automatic int model_idx(input logic [9:0] fv);
        int r;
        r = 0;
        for (int k = 0; k < 10; k++)
            if (fv[k]) r = k + 1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a = 11'h7FF;
        f = 10'h3FF;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_async: bigout=%b sel_idx=%0d, required 0/0", bigout, sel_idx);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bigout !== 1'b0 || sel_idx !== 4'd0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: bigout=%b sel_idx=%0d, required 0/0", i, bigout, sel_idx);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_f_zero();
        f = 10'h000;
        a = 11'h001;
        tick();
        tests_run++;
        if (bigout !== 1'b1 || sel_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL f_zero_one: bigout=%b sel_idx=%0d, required 1/0", bigout, sel_idx);
        end
        a = 11'h7FE;
        tick();
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL f_zero_zero: bigout=%b sel_idx=%0d, required 0/0", bigout, sel_idx);
        end
    endtask

    task automatic test_single_sel();
        f = 10'b00_0000_0100;
        a = 11'h008;
        tick();
        tests_run++;
        if (bigout !== 1'b1 || sel_idx !== 4'd3) begin
            tests_failed++;
            $display("FAIL single_one: bigout=%b sel_idx=%0d, required 1/3", bigout, sel_idx);
        end
        a = 11'h7F7;
        tick();
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd3) begin
            tests_failed++;
            $display("FAIL single_zero: bigout=%b sel_idx=%0d, required 0/3", bigout, sel_idx);
        end
    endtask

    task automatic test_priority();
        f = 10'b00_0010_0101;
        a = 11'h040;
        tick();
        tests_run++;
        if (bigout !== 1'b1 || sel_idx !== 4'd6) begin
            tests_failed++;
            $display("FAIL priority_one: bigout=%b sel_idx=%0d, required 1/6", bigout, sel_idx);
        end
        a = 11'h7BF;
        tick();
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd6) begin
            tests_failed++;
            $display("FAIL priority_zero: bigout=%b sel_idx=%0d, required 0/6", bigout, sel_idx);
        end
    endtask

    task automatic test_top_and_midreset();
        f = 10'h3FF;
        a = 11'h400;
        tick();
        tests_run++;
        if (bigout !== 1'b1 || sel_idx !== 4'd10) begin
            tests_failed++;
            $display("FAIL top_one: bigout=%b sel_idx=%0d, required 1/10", bigout, sel_idx);
        end
        a = 11'h3FF;
        tick();
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd10) begin
            tests_failed++;
            $display("FAIL top_zero: bigout=%b sel_idx=%0d, required 0/10", bigout, sel_idx);
        end
        a = 11'h400;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: bigout=%b sel_idx=%0d, required 0/0", bigout, sel_idx);
        end
        tick();
        tests_run++;
        if (bigout !== 1'b0 || sel_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL midreset_hold: bigout=%b sel_idx=%0d, required 0/0", bigout, sel_idx);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (bigout !== 1'b1 || sel_idx !== 4'd10) begin
            tests_failed++;
            $display("FAIL midreset_release: bigout=%b sel_idx=%0d, required 1/10", bigout, sel_idx);
        end
    endtask

    task automatic test_random();
        data_vec_t prev_a;
        sel_vec_t  prev_f;
        int        exp_idx;
        logic      exp_out;
        prev_a = 11'h5A5;
        prev_f = 10'h012;
        a = prev_a;
        f = prev_f;
        tick();
        for (int i = 0; i < 100; i++) begin
            exp_idx = model_idx(prev_f);
            exp_out = prev_a[exp_idx];
            tests_run++;
            if (bigout !== exp_out || sel_idx !== idx_t'(exp_idx)) begin
                tests_failed++;
                $display("FAIL random[%0d] a=%h f=%h: bigout=%b sel_idx=%0d, required %b/%0d",
                         i, prev_a, prev_f, bigout, sel_idx, exp_out, exp_idx);
            end
            prev_a = data_vec_t'($urandom_range(0, 2047));
            prev_f = sel_vec_t'($urandom_range(0, 1023));
            a = prev_a;
            f = prev_f;
            tick();
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b1;
        a = '0;
        f = '0;
        test_reset();
        test_f_zero();
        test_single_sel();
        test_priority();
        test_top_and_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
